// File: rtl/vx_pending_alloc.sv
// Shared pool of pending-request tags handed out round-robin to several requesters.
// One allocation per cycle; a release returns a tag to the pool and debits its owner.
module vx_pending_alloc #(
   parameter int NUM_REQS    = 4,
   parameter int SIZE        = 8,
   parameter int MAX_PER_REQ = SIZE,
   parameter int TAGW        = $clog2(SIZE),
   parameter int SIZEW       = $clog2(SIZE + 1),
   parameter int REQW        = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NUM_REQS-1:0] req_valid,
   output logic [NUM_REQS-1:0] req_ready,
   output logic [TAGW-1:0]     alloc_tag,
   input  logic                rel_valid,
   input  logic [TAGW-1:0]     rel_tag,
   output logic                empty,
   output logic                full,
   output logic [SIZEW-1:0]    size
);

   logic [SIZE-1:0]     r_freeMask;
   logic [REQW-1:0]     r_owner [SIZE];
   logic [SIZEW-1:0]    r_count [NUM_REQS];
   logic [SIZEW-1:0]    r_used;
   logic                r_empty;
   logic                r_full;
   logic [REQW-1:0]     r_rrPtr;

   logic [NUM_REQS-1:0] w_eligible;
   logic                w_grantAny;
   logic [REQW-1:0]     w_grantIdx;
   logic                w_grant;
   logic [TAGW-1:0]     w_allocTag;
   logic [REQW-1:0]     w_relOwner;
   logic [NUM_REQS-1:0] w_cntInc;
   logic [NUM_REQS-1:0] w_cntDec;

   always_comb begin
      w_eligible = '0;
      for (int i = 0; i < NUM_REQS; i++) begin
         w_eligible[i] = req_valid[i] && (r_count[i] < SIZEW'(MAX_PER_REQ));
      end
   end

   // Round-robin search starting at the pointer and wrapping around.
   always_comb begin
      w_grantAny = 1'b0;
      w_grantIdx = '0;
      for (int k = 0; k < NUM_REQS; k++) begin
         if (!w_grantAny && w_eligible[(int'(r_rrPtr) + k) % NUM_REQS]) begin
            w_grantAny = 1'b1;
            w_grantIdx = REQW'((int'(r_rrPtr) + k) % NUM_REQS);
         end
      end
   end

   // No grant while full, even if a tag is released in the same cycle.
   assign w_grant = w_grantAny && !r_full && !reset;

   always_comb begin
      w_allocTag = '0;
      for (int i = SIZE - 1; i >= 0; i--) begin
         if (r_freeMask[i]) begin
            w_allocTag = TAGW'(i);
         end
      end
   end

   assign w_relOwner = r_owner[rel_tag];

   always_comb begin
      w_cntInc = '0;
      w_cntDec = '0;
      for (int i = 0; i < NUM_REQS; i++) begin
         w_cntInc[i] = w_grant && (w_grantIdx == REQW'(i));
         w_cntDec[i] = rel_valid && (w_relOwner == REQW'(i));
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_freeMask <= '1;
         r_used     <= '0;
         r_empty    <= 1'b1;
         r_full     <= 1'b0;
         r_rrPtr    <= '0;
         for (int i = 0; i < SIZE; i++) begin
            r_owner[i] <= '0;
         end
         for (int i = 0; i < NUM_REQS; i++) begin
            r_count[i] <= '0;
         end
      end else begin
         if (w_grant) begin
            r_freeMask[w_allocTag] <= 1'b0;
            r_owner[w_allocTag]    <= w_grantIdx;
            r_rrPtr <= (w_grantIdx == REQW'(NUM_REQS - 1)) ? '0 : w_grantIdx + 1'b1;
         end
         if (rel_valid) begin
            r_freeMask[rel_tag] <= 1'b1;
         end
         for (int i = 0; i < NUM_REQS; i++) begin
            if (w_cntInc[i] && !w_cntDec[i]) begin
               r_count[i] <= r_count[i] + 1'b1;
            end else if (!w_cntInc[i] && w_cntDec[i]) begin
               r_count[i] <= r_count[i] - 1'b1;
            end
         end
         // Empty/full only flip on an edge of the occupancy count.
         if (w_grant && !rel_valid) begin
            r_used <= r_used + 1'b1;
            if (r_used == SIZEW'(SIZE - 1)) r_full  <= 1'b1;
            if (r_used == '0)               r_empty <= 1'b0;
         end else if (!w_grant && rel_valid) begin
            r_used <= r_used - 1'b1;
            if (r_used == SIZEW'(1))    r_empty <= 1'b1;
            if (r_used == SIZEW'(SIZE)) r_full  <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         assert (!(rel_valid && ({1'b0, rel_tag} >= (TAGW + 1)'(SIZE))));
         assert (!(rel_valid && r_freeMask[rel_tag]));
         assert (!(r_full && (req_ready != '0)));
         assert ($onehot0(req_ready));
      end
   end

   assign req_ready = w_grant ? (NUM_REQS'(1) << w_grantIdx) : '0;
   assign alloc_tag = w_allocTag;
   assign empty     = r_empty;
   assign full      = r_full;
   assign size      = r_used;

endmodule

// File: tb/tb_vx_pending_alloc.sv
// Directed bench for vx_pending_alloc with a 2-requester, 4-slot pool and a limit of 3 per requester.
module tb_vx_pending_alloc;

   logic       clk;
   logic       reset;
   logic [1:0] req_valid;
   logic [1:0] req_ready;
   logic [1:0] alloc_tag;
   logic       rel_valid;
   logic [1:0] rel_tag;
   logic       empty;
   logic       full;
   logic [2:0] size;

   int assertCount = 0;
   int failCount   = 0;

   vx_pending_alloc #(
      .NUM_REQS    (2),
      .SIZE        (4),
      .MAX_PER_REQ (3)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .alloc_tag (alloc_tag),
      .rel_valid (rel_valid),
      .rel_tag   (rel_tag),
      .empty     (empty),
      .full      (full),
      .size      (size)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compares one observed value against the expected one and tallies the result.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   // Advances one clock edge; inputs changed afterwards land safely between edges.
   task automatic applyStimulus(input logic rst, input logic [1:0] rv, input logic relV, input logic [1:0] relT);
      @(posedge clk);
      #1;
      reset     = rst;
      req_valid = rv;
      rel_valid = relV;
      rel_tag   = relT;
      #2;
   endtask

   initial begin
      reset     = 1'b1;
      req_valid = 2'b11;
      rel_valid = 1'b0;
      rel_tag   = 2'd0;
      #3;
      checkOutput("readyDuringReset", req_ready, 2'b00);
      applyStimulus(1'b1, 2'b11, 1'b0, 2'd0);
      checkOutput("readyDuringReset2", req_ready, 2'b00);

      // Both requesters asking: alternating grants fill the pool.
      applyStimulus(1'b0, 2'b11, 1'b0, 2'd0);
      checkOutput("resetSize", size, 3'd0);
      checkOutput("resetEmpty", empty, 1'b1);
      checkOutput("resetFull", full, 1'b0);
      checkOutput("g1Ready", req_ready, 2'b01);
      checkOutput("g1Tag", alloc_tag, 2'd0);
      applyStimulus(1'b0, 2'b11, 1'b0, 2'd0);
      checkOutput("g2Ready", req_ready, 2'b10);
      checkOutput("g2Tag", alloc_tag, 2'd1);
      checkOutput("g2Empty", empty, 1'b0);
      applyStimulus(1'b0, 2'b11, 1'b0, 2'd0);
      checkOutput("g3Ready", req_ready, 2'b01);
      checkOutput("g3Tag", alloc_tag, 2'd2);
      applyStimulus(1'b0, 2'b11, 1'b0, 2'd0);
      checkOutput("g4Ready", req_ready, 2'b10);
      checkOutput("g4Tag", alloc_tag, 2'd3);
      applyStimulus(1'b0, 2'b11, 1'b0, 2'd0);
      checkOutput("fullFlag", full, 1'b1);
      checkOutput("fullSize", size, 3'd4);
      checkOutput("fullReady", req_ready, 2'b00);

      // Release while full: no same-cycle grant, tag reused next cycle.
      applyStimulus(1'b0, 2'b01, 1'b1, 2'd2);
      checkOutput("relFullReady", req_ready, 2'b00);
      applyStimulus(1'b0, 2'b01, 1'b0, 2'd0);
      checkOutput("afterRelFull", full, 1'b0);
      checkOutput("afterRelSize", size, 3'd3);
      checkOutput("reuseReady", req_ready, 2'b01);
      checkOutput("reuseTag", alloc_tag, 2'd2);
      applyStimulus(1'b0, 2'b00, 1'b0, 2'd0);
      checkOutput("refillSize", size, 3'd4);
      checkOutput("refillFull", full, 1'b1);

      // Drop to 3 outstanding, then reset mid-operation.
      applyStimulus(1'b0, 2'b00, 1'b1, 2'd3);
      applyStimulus(1'b0, 2'b00, 1'b0, 2'd0);
      checkOutput("threeSize", size, 3'd3);
      checkOutput("threeFull", full, 1'b0);
      applyStimulus(1'b1, 2'b00, 1'b0, 2'd0);
      applyStimulus(1'b0, 2'b01, 1'b0, 2'd0);
      checkOutput("midResetSize", size, 3'd0);
      checkOutput("midResetEmpty", empty, 1'b1);
      checkOutput("midResetFull", full, 1'b0);
      checkOutput("midResetReady", req_ready, 2'b01);
      checkOutput("midResetTag", alloc_tag, 2'd0);

      // Single requester runs into its limit of three.
      applyStimulus(1'b0, 2'b01, 1'b0, 2'd0);
      checkOutput("lim2Ready", req_ready, 2'b01);
      checkOutput("lim2Tag", alloc_tag, 2'd1);
      applyStimulus(1'b0, 2'b01, 1'b0, 2'd0);
      checkOutput("lim3Ready", req_ready, 2'b01);
      checkOutput("lim3Tag", alloc_tag, 2'd2);
      applyStimulus(1'b0, 2'b01, 1'b0, 2'd0);
      checkOutput("limBlocked", req_ready, 2'b00);
      checkOutput("limSize", size, 3'd3);
      applyStimulus(1'b0, 2'b01, 1'b1, 2'd1);
      checkOutput("limRelReady", req_ready, 2'b00);
      applyStimulus(1'b0, 2'b01, 1'b0, 2'd0);
      checkOutput("limReenReady", req_ready, 2'b01);
      checkOutput("limReenTag", alloc_tag, 2'd1);
      checkOutput("limReenSize", size, 3'd2);
      applyStimulus(1'b0, 2'b00, 1'b0, 2'd0);
      checkOutput("limFinalSize", size, 3'd3);

      // One tag held by req0; req1 allocates while req0 releases.
      applyStimulus(1'b1, 2'b00, 1'b0, 2'd0);
      applyStimulus(1'b0, 2'b01, 1'b0, 2'd0);
      applyStimulus(1'b0, 2'b10, 1'b1, 2'd0);
      checkOutput("swapSizeBefore", size, 3'd1);
      checkOutput("swapReady", req_ready, 2'b10);
      checkOutput("swapTag", alloc_tag, 2'd1);
      applyStimulus(1'b0, 2'b00, 1'b0, 2'd0);
      checkOutput("swapSize", size, 3'd1);
      checkOutput("swapEmpty", empty, 1'b0);
      checkOutput("swapCount0", dut.r_count[0], 3'd0);
      checkOutput("swapCount1", dut.r_count[1], 3'd1);

      // Releasing the last outstanding tag empties the pool.
      applyStimulus(1'b0, 2'b00, 1'b1, 2'd1);
      checkOutput("lastRelEmptyHold", empty, 1'b0);
      applyStimulus(1'b0, 2'b00, 1'b0, 2'd0);
      checkOutput("lastRelEmpty", empty, 1'b1);
      checkOutput("lastRelSize", size, 3'd0);
      checkOutput("lastRelCount1", dut.r_count[1], 3'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
